// File: rtl/hog_svm_pkg.sv
// Shared definitions for the HOG/SVM detection path: default field widths,
// the queued detection record and a saturating counter helper.
package hog_svm_pkg;

  localparam int DEF_FEA_W = 16;
  localparam int DEF_SW_W  = 11;
  localparam int DEF_CH_W  = 3;

  typedef struct packed {
    logic [DEF_CH_W-1:0]  ch;
    logic [DEF_SW_W-1:0]  sw_id;
    logic [DEF_FEA_W-1:0] score;
  } det_entry_t;

  // Adds inc to value and clamps the result at max_val instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] value,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, value} + {1'b0, inc};
    sat_add = (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/det_fifo.sv
// Synchronous show-ahead FIFO of detection records; push is accepted on a
// full FIFO when a pop happens in the same cycle.
module det_fifo import hog_svm_pkg::*; #(
  parameter type T     = det_entry_t,
  parameter int  DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // Storage is not reset, so the head reads as zero while nothing is queued.
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/svm_det_queue.sv
// Multi-channel SVM detection collector: per-channel pending score, threshold
// compare, round-robin push into a shared FIFO. Stats counters: SVM_DET_STATS_EN.
module svm_det_queue import hog_svm_pkg::*; #(
  parameter int N_CH  = 2,
  parameter int FEA_W = DEF_FEA_W,
  parameter int SW_W  = DEF_SW_W,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int CH_W  = DEF_CH_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       i_valid,
  input  logic [N_CH*FEA_W-1:0] i_score,
  input  logic [N_CH*SW_W-1:0]  i_sw_id,
  input  logic                  thr_load,
  input  logic [CH_W-1:0]       thr_ch,
  input  logic [FEA_W-1:0]      thr_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [CH_W-1:0]       o_ch,
  output logic [SW_W-1:0]       o_sw_id,
  output logic [FEA_W-1:0]      o_score,
  output logic                  full,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      det_cnt
);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [SW_W-1:0]  sw_id;
    logic [FEA_W-1:0] score;
  } entry_t;

  logic signed [FEA_W-1:0] p_score [N_CH];
  logic [SW_W-1:0]         p_sw    [N_CH];
  logic signed [FEA_W-1:0] thr     [N_CH];
  logic [N_CH-1:0]         pend;
  logic [N_CH-1:0]         pass;
  logic [N_CH-1:0]         grant;
  logic [N_CH-1:0]         clr;
  logic [CH_W-1:0]         rr_ptr;
  logic                    grant_any;
  logic [CH_W-1:0]         grant_ch;
  logic                    pop;
  logic                    can_push;
  logic                    fifo_full;
  logic                    fifo_empty;
  entry_t                  push_entry;
  entry_t                  head;

  // Host side is strict valid/ready: an entry transfers on any cycle where
  // o_valid && o_ready; o_* hold steady while o_valid is high and o_ready low.
  assign pop      = o_valid && o_ready;
  assign can_push = !fifo_full || pop;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      pass[c] = pend[c] && (p_score[c] > thr[c]);
    end
  end

  // Round robin: first passing channel at or above rr_ptr, else wrap to below.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (can_push && !grant_any && pass[c] && (c >= int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'(c);
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (can_push && !grant_any && pass[c] && (c < int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'(c);
      end
    end
  end

  always_comb begin
    push_entry = '0;
    for (int c = 0; c < N_CH; c++) begin
      grant[c] = grant_any && (grant_ch == CH_W'(c));
      clr[c]   = pend[c] && (!pass[c] || grant[c]);
      if (grant[c]) begin
        push_entry.ch    = CH_W'(c);
        push_entry.sw_id = p_sw[c];
        push_entry.score = p_score[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      rr_ptr <= '0;
      for (int c = 0; c < N_CH; c++) thr[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_valid[c])  pend[c] <= 1'b1;
        else if (clr[c]) pend[c] <= 1'b0;
        // Selects of thr_ch >= N_CH match no channel and are dropped.
        if (thr_load && (thr_ch == CH_W'(c))) thr[c] <= thr_data;
      end
      if (grant_any) begin
        rr_ptr <= (int'(grant_ch) == N_CH - 1) ? '0 : grant_ch + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (i_valid[c]) begin
        p_score[c] <= i_score[c*FEA_W +: FEA_W];
        p_sw[c]    <= i_sw_id[c*SW_W +: SW_W];
      end
    end
  end

  det_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_any),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign o_valid = !fifo_empty;
  assign o_ch    = head.ch;
  assign o_sw_id = head.sw_id;
  assign o_score = head.score;
  assign full    = fifo_full;

`ifdef SVM_DET_STATS_EN
  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  logic [N_CH-1:0]  drop;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] det_q;

  // A drop is a new strobe landing on a pending entry that is not leaving.
  assign drop = i_valid & pend & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      det_q  <= '0;
    end else begin
      drop_q <= CNT_W'(sat_add(32'(drop_q), 32'($countones(drop)), CNT_MAX));
      det_q  <= CNT_W'(sat_add(32'(det_q), 32'(grant_any), CNT_MAX));
    end
  end

  assign drop_cnt = drop_q;
  assign det_cnt  = det_q;
`else
  assign drop_cnt = '0;
  assign det_cnt  = '0;
`endif

endmodule

// File: tb/tb_svm_det_queue.sv
// Self-checking bench for svm_det_queue: directed scenarios plus random
// traffic against a queue-based behavioural model.
module tb_svm_det_queue;

  localparam int N_CH  = 2;
  localparam int FEA_W = 16;
  localparam int SW_W  = 11;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int CH_W  = 3;
  localparam int EW    = CH_W + SW_W + FEA_W;
  localparam int BW    = 2 + EW + 2*CNT_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       i_valid;
  logic [N_CH*FEA_W-1:0] i_score;
  logic [N_CH*SW_W-1:0]  i_sw_id;
  logic                  thr_load;
  logic [CH_W-1:0]       thr_ch;
  logic [FEA_W-1:0]      thr_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [CH_W-1:0]       o_ch;
  logic [SW_W-1:0]       o_sw_id;
  logic [FEA_W-1:0]      o_score;
  logic                  full;
  logic [CNT_W-1:0]      drop_cnt;
  logic [CNT_W-1:0]      det_cnt;

  always #5 clk = ~clk;

  svm_det_queue #(
    .N_CH (N_CH), .FEA_W (FEA_W), .SW_W (SW_W),
    .DEPTH (DEPTH), .CNT_W (CNT_W), .CH_W (CH_W)
  ) dut (
    .clk (clk), .rst (rst),
    .i_valid (i_valid), .i_score (i_score), .i_sw_id (i_sw_id),
    .thr_load (thr_load), .thr_ch (thr_ch), .thr_data (thr_data),
    .o_valid (o_valid), .o_ready (o_ready),
    .o_ch (o_ch), .o_sw_id (o_sw_id), .o_score (o_score),
    .full (full), .drop_cnt (drop_cnt), .det_cnt (det_cnt)
  );

  // ---------------- reference model ----------------
  logic [EW-1:0]    exp_q[$];
  bit               m_pend [N_CH];
  logic [FEA_W-1:0] m_ps   [N_CH];
  logic [SW_W-1:0]  m_psw  [N_CH];
  logic [FEA_W-1:0] m_thr  [N_CH];
  int               m_rr;
  int               m_drop;
  int               m_det;
  int               checks;
  int               failures;
  logic [BW-1:0]    obs;
  logic [BW-1:0]    exp_b;

  // Head fields are only meaningful while o_valid is high.
  assign obs = {o_valid, full, (o_valid ? {o_ch, o_sw_id, o_score} : EW'(0)), drop_cnt, det_cnt};

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_step();
    bit pass [N_CH];
    bit pop;
    bit can;
    bit clr;
    int g;
    int ndrop;
    pop = (exp_q.size() > 0) && o_ready;
    if (rst) begin
      exp_q.delete();
      for (int c = 0; c < N_CH; c++) begin
        m_pend[c] = 0;
        m_thr[c]  = '0;
      end
      m_rr = 0; m_drop = 0; m_det = 0;
      return;
    end
    for (int c = 0; c < N_CH; c++) pass[c] = m_pend[c] && ($signed(m_ps[c]) > $signed(m_thr[c]));
    can = (exp_q.size() < DEPTH) || pop;
    g = -1;
    if (can) begin
      for (int k = 0; k < N_CH; k++) begin
        int c;
        c = (m_rr + k) % N_CH;
        if (g < 0 && pass[c]) g = c;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back({CH_W'(g), m_psw[g], m_ps[g]});
      m_rr  = (g + 1) % N_CH;
      m_det = (m_det < CMAX) ? m_det + 1 : m_det;
    end
    ndrop = 0;
    for (int c = 0; c < N_CH; c++) begin
      clr = m_pend[c] && (!pass[c] || c == g);
      if (i_valid[c]) begin
        if (m_pend[c] && !clr) ndrop++;
        m_pend[c] = 1;
        m_ps[c]   = i_score[c*FEA_W +: FEA_W];
        m_psw[c]  = i_sw_id[c*SW_W +: SW_W];
      end else if (clr) begin
        m_pend[c] = 0;
      end
    end
    m_drop = (m_drop + ndrop > CMAX) ? CMAX : m_drop + ndrop;
    for (int c = 0; c < N_CH; c++) if (thr_load && int'(thr_ch) == c) m_thr[c] = thr_data;
  endtask

  function automatic logic [BW-1:0] exp_bundle();
    logic [EW-1:0]    h;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] t;
    h = (exp_q.size() > 0) ? exp_q[0] : EW'(0);
`ifdef SVM_DET_STATS_EN
    d = CNT_W'(m_drop);
    t = CNT_W'(m_det);
`else
    d = '0;
    t = '0;
`endif
    return {exp_q.size() > 0, exp_q.size() == DEPTH, h, d, t};
  endfunction

  function automatic int stat_exp(input int v);
`ifdef SVM_DET_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    i_valid  = '0;
    thr_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe(input int c, input logic [FEA_W-1:0] s, input logic [SW_W-1:0] sw);
    i_valid[c] = 1'b1;
    i_score[c*FEA_W +: FEA_W] = s;
    i_sw_id[c*SW_W +: SW_W]   = sw;
  endtask

  task automatic load_thr(input int c, input logic [FEA_W-1:0] v);
    thr_load = 1'b1;
    thr_ch   = CH_W'(c);
    thr_data = v;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({o_valid, full, o_ch, o_sw_id, o_score, drop_cnt, det_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b f=%0b ch=%0d sw=%0d sc=%h drop=%0d det=%0d want all 0",
               o_valid, full, o_ch, o_sw_id, o_score, drop_cnt, det_cnt);
    end
  endtask

  task automatic test_basic();
    load_thr(0, 16'h0100);
    tick();
    strobe(0, 16'h0200, 11'd5);
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_t1_valid got %0b want 0", o_valid);
    end
    tick();
    checks++;
    if ({o_valid, o_ch, o_sw_id, o_score} !== {1'b1, 3'd0, 11'd5, 16'h0200}) begin
      failures++;
      $display("FAIL basic_t2_head got v=%0b ch=%0d sw=%0d sc=%h want v=1 ch=0 sw=5 sc=0200",
               o_valid, o_ch, o_sw_id, o_score);
    end
    checks++;
    if (int'(det_cnt) !== stat_exp(1)) begin
      failures++;
      $display("FAIL basic_det_cnt got %0d want %0d", det_cnt, stat_exp(1));
    end
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    exp_b = exp_bundle();
    checks++;
    if (obs !== exp_b) begin
      failures++;
      $display("FAIL basic_pop got %h want %h", obs, exp_b);
    end
  endtask

  task automatic test_threshold_edge();
    strobe(0, 16'h0100, 11'd7);
    strobe(1, 16'hF000, 11'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_valid !== 1'b0 || int'(det_cnt) !== stat_exp(1) || int'(drop_cnt) !== 0) begin
        failures++;
        $display("FAIL thr_edge_c%0d got v=%0b det=%0d drop=%0d want v=0 det=%0d drop=0",
                 k, o_valid, det_cnt, drop_cnt, stat_exp(1));
      end
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int want[$];
    pulse_reset();
    o_ready = 1'b1;
    // pair from rr 0, single ch0 (rr -> 1), then pair from rr 1
    want = '{0, 1, 0, 1, 0};
    for (int phase = 0; phase < 3; phase++) begin
      if (phase == 1) begin
        strobe(0, 16'h0030, 11'd30);
      end else begin
        strobe(0, 16'h0010 + 16'(phase), 11'(10 + phase));
        strobe(1, 16'h0020 + 16'(phase), 11'(20 + phase));
      end
      for (int k = 0; k < 4; k++) begin
        tick();
        exp_b = exp_bundle();
        checks++;
        if (obs !== exp_b) begin
          failures++;
          $display("FAIL rr_p%0d_c%0d got %h want %h", phase, k, obs, exp_b);
        end
        if (o_valid) got.push_back(int'(o_ch));
      end
    end
    o_ready = 1'b0;
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL rr_order got %p want %p", got, want);
    end
  endtask

  task automatic test_overflow();
    pulse_reset();
    o_ready = 1'b0;
    for (int n = 0; n <= DEPTH; n++) begin
      strobe(0, 16'h0100 + 16'(n), 11'(n));
      for (int k = 0; k < 2; k++) begin
        tick();
        exp_b = exp_bundle();
        checks++;
        if (obs !== exp_b) begin
          failures++;
          $display("FAIL ovf_n%0d_c%0d got %h want %h", n, k, obs, exp_b);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || o_sw_id !== 11'd0) begin
      failures++;
      $display("FAIL ovf_full got full=%0b head_sw=%0d want full=1 head_sw=0", full, o_sw_id);
    end
    for (int n = 0; n < 3; n++) begin
      strobe(0, 16'h0200 + 16'(n), 11'(100 + n));
      tick();
    end
    checks++;
    if (int'(drop_cnt) !== stat_exp(3) || full !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drops got drop=%0d full=%0b want drop=%0d full=1", drop_cnt, full, stat_exp(3));
    end
  endtask

  task automatic test_full_push_pop();
    // pending ch0 entry (sw 102) goes in as the head leaves; a same-cycle
    // strobe lands without counting a drop
    o_ready = 1'b1;
    strobe(0, 16'h0300, 11'd200);
    tick();
    o_ready = 1'b0;
    checks++;
    if (full !== 1'b1 || o_sw_id !== 11'd1 || int'(drop_cnt) !== stat_exp(3)) begin
      failures++;
      $display("FAIL fullpp got full=%0b head_sw=%0d drop=%0d want full=1 head_sw=1 drop=%0d",
               full, o_sw_id, drop_cnt, stat_exp(3));
    end
    exp_b = exp_bundle();
    checks++;
    if (obs !== exp_b) begin
      failures++;
      $display("FAIL fullpp_model got %h want %h", obs, exp_b);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    load_thr(0, 16'h0400);
    tick();
    load_thr(1, 16'h0400);
    tick();
    for (int n = 0; n < DEPTH/2; n++) begin
      strobe(0, 16'h0500 + 16'(n), 11'(n));
      tick();
    end
    tick();
    pulse_reset();
    checks++;
    if ({o_valid, full, o_ch, o_sw_id, o_score, drop_cnt, det_cnt} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got v=%0b f=%0b sw=%0d sc=%h drop=%0d det=%0d want all 0",
               o_valid, full, o_sw_id, o_score, drop_cnt, det_cnt);
    end
    // below the old threshold, above zero: only passes if thresholds cleared
    strobe(1, 16'h0050, 11'd9);
    tick();
    tick();
    checks++;
    if ({o_valid, o_ch, o_sw_id, o_score} !== {1'b1, 3'd1, 11'd9, 16'h0050}) begin
      failures++;
      $display("FAIL midrst_thr got v=%0b ch=%0d sw=%0d sc=%h want v=1 ch=1 sw=9 sc=0050",
               o_valid, o_ch, o_sw_id, o_score);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 9) < 4) strobe(c, 16'($urandom), 11'($urandom));
      end
      if ($urandom_range(0, 19) == 0) load_thr($urandom_range(0, 3), 16'($urandom_range(0, 16'h1FFF)) - 16'h0800);
      o_ready = ((k / 150) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 699) == 0);
      tick();
      rst = 1'b0;
      exp_b = exp_bundle();
      checks++;
      if (obs !== exp_b) begin
        failures++;
        if (bad < 10) $display("FAIL rand_c%0d got %h want %h", k, obs, exp_b);
        bad++;
      end
    end
    o_ready = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0; failures = 0;
    m_rr = 0; m_drop = 0; m_det = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_pend[c] = 0; m_thr[c] = '0; m_ps[c] = '0; m_psw[c] = '0;
    end
    rst = 1'b1; i_valid = '0; i_score = '0; i_sw_id = '0;
    thr_load = 1'b0; thr_ch = '0; thr_data = '0; o_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_threshold_edge();
    test_round_robin();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
